// File: rtl/nearhit_writer.sv
// Buffers nearest-hit results per ray and streams each one as a 6-word 16-bit burst.
// Latency: head appears one edge after capture; datawant low stalls the burst in place, and a full FIFO drops new rays (sticky overflow).

module nearhit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          globalreset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (!globalreset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdat;
  end

  assign rdat = mem[rptr];

endmodule

module nearhit_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        globalreset,
  input  logic [31:0] t,
  input  logic [15:0] u,
  input  logic [15:0] v,
  input  logic [15:0] triID,
  input  logic        anyhit,
  input  logic        raydone,
  output logic [15:0] dataout,
  output logic        datavalid,
  input  logic        datawant,
  output logic        full,
  output logic        overflow,
  output logic [11:0] raycount
);

  typedef struct packed {
    logic [11:0] ray_id;
    logic        anyhit;
    logic [31:0] t;
    logic [15:0] u;
    logic [15:0] v;
    logic [15:0] tri_id;
  } hit_entry_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic [2:0] widx_q, widx_d;
  hit_entry_t hold_q, hold_d;
  hit_entry_t wr_entry, head;
  logic [AW:0] count;
  logic        accept;
  logic        pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign accept   = raydone & ~full;
  assign wr_entry = {raycount, anyhit, t, u, v, triID};

  nearhit_fifo #(
    .W     ($bits(hit_entry_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .globalreset (globalreset),
    .push        (accept),
    .pop         (pop),
    .wdat        (wr_entry),
    .rdat        (head),
    .count       (count)
  );

  always_ff @(posedge clk) begin
    if (!globalreset) begin
      raycount <= '0;
      overflow <= 1'b0;
    end else if (raydone) begin
      raycount <= raycount + 12'd1;
      if (full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!globalreset) begin
      state_q <= IDLE;
      widx_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    datavalid = 1'b0;
    dataout   = '0;
    case (state_q)
      IDLE: begin
        // Head stays in the FIFO until its last word is accepted.
        if (count != '0) begin
          hold_d  = head;
          widx_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        datavalid = 1'b1;
        case (widx_q)
          3'd0:    dataout = {hold_q.anyhit, 3'b000, hold_q.ray_id};
          3'd1:    dataout = hold_q.t[31:16];
          3'd2:    dataout = hold_q.t[15:0];
          3'd3:    dataout = hold_q.u;
          3'd4:    dataout = hold_q.v;
          3'd5:    dataout = hold_q.tri_id;
          default: dataout = '0;
        endcase
        // A miss carries stale comparator values; only the header is meaningful.
        if (!hold_q.anyhit && widx_q != 3'd0) dataout = '0;
        if (datawant) begin
          if (widx_q == 3'd5) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            widx_d = widx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/nearhit_writer.md
Name: nearhit_writer

Overview:
- Downstream of the nearest-hit comparator in the ray/triangle intersection pipeline.
- On each end-of-ray strobe, captures the comparator's held result (t, u, v, triID, anyhit) into a small FIFO. Each entry is tagged with a running ray number.
- Streams each entry out as a fixed 6-word, 16-bit burst over a valid/want handshake to the result-memory writer.
- Decouples the intersection loop from a stalling output path.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, ≥2)
- AW, 2, log2(DEPTH); FIFO pointer width

Ports:
- clk  input  1  clock; all logic on rising edge
- globalreset  input  1  synchronous, active-low reset (0 = reset)
- t  input  32  nearest hit distance from comparator
- u  input  16  barycentric u of nearest hit
- v  input  16  barycentric v of nearest hit
- triID  input  16  triangle ID of nearest hit
- anyhit  input  1  1 = at least one hit recorded for this ray
- raydone  input  1  single-cycle strobe: current ray's triangle list finished; inputs valid this cycle
- dataout  output  16  burst word
- datavalid  output  1  dataout valid
- datawant  input  1  consumer ready; a word transfers when datavalid & datawant
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a raydone was dropped
- raycount  output  12  rays seen since reset (wraps 4095→0)

Behaviour:
- Reset (globalreset low at clk edge):
  - FIFO empty, pointers/count 0, state IDLE.
  - dataout=0, datavalid=0, full=0, overflow=0, raycount=0.
  - Any burst in progress is aborted; datavalid low after that edge.
- Capture:
  - On an edge with raydone=1, raycount increments (mod 4096).
  - If registered count < DEPTH, write entry {rayID=raycount (pre-increment), anyhit, t, u, v, triID} and advance the write pointer.
  - Else drop the entry and set overflow=1 (stays set until reset).
- Fullness check and simultaneous events:
  - Fullness is checked on the registered count. A pop in the same cycle does not free space for that cycle's write.
  - Simultaneous write and pop leaves count unchanged.
- Output FSM, states IDLE and SEND:
  - IDLE:
    - datavalid=0.
    - If count>0: copy head entry into an output holding register, widx=0, go to SEND. The head is not popped yet.
  - SEND:
    - datavalid=1; dataout=word[widx].
    - On transfer with widx<5: widx+1.
    - On transfer with widx==5: pop the head, return to IDLE.
    - No transfer: hold dataout and widx unchanged; no timeout.
- Burst word order:
  - 0 = {anyhit, 3'b000, rayID[11:0]}
  - 1 = t[31:16]
  - 2 = t[15:0]
  - 3 = u
  - 4 = v
  - 5 = triID
  - If anyhit=0, words 1–5 are sent as 0, regardless of the stale comparator values.
- Latency: raydone with the FIFO empty in IDLE → datavalid high two edges after the capture edge. There is one IDLE bubble cycle between consecutive bursts.
- Minimum burst length is 6 cycles with datawant held at 1.
- full is derived combinationally from the registered count. raycount and overflow are registered outputs.

Test Plan:
- Single ray: t=0x00010020, u=0x1111, v=0x2222, triID=0x0042, anyhit=1, raydone pulse, datawant=1 → datavalid rises 2 edges later. Words are 0x8000, 0x0001, 0x0020, 0x1111, 0x2222, 0x0042 on consecutive cycles, then datavalid=0 for 1 cycle. raycount=1.
- Miss ray: anyhit=0 with nonzero stale t/u/v/triID as second ray → words 0x0001, 0, 0, 0, 0, 0.
- Backpressure: datawant=0 for 5 cycles during word 2 → dataout stays 0x0020 with datavalid=1. The burst resumes with word 3 when datawant=1, and no word is lost or duplicated.
- Overflow: datawant=0, 5 raydone pulses with DEPTH=4 → full=1 after the 4th, overflow=1 after the 5th, raycount=5. Releasing datawant yields exactly 4 bursts with rayIDs 0–3.
- Simultaneous pop and write: FIFO full, raydone on the same edge as the final word-5 transfer → entry dropped, overflow=1, count=3 after the edge.
- Reset mid-burst: globalreset=0 during word 3 → after the edge datavalid=0, full=0, overflow=0, raycount=0. With globalreset=1 again, no output until a new raydone.
